// File: rtl/cap_pkg.sv
// Shared types and geometry for the logic-analyzer capture front end.
package cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    localparam int NUM_SLOTS      = 4;
    localparam int WORD_W         = 32;
    localparam int SAMPLE_W       = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sample_tick_gen.sv
// Prescaler for the probe sampling rate: one-cycle tick every PRESCALER clocks,
// restartable from zero through a synchronous clear.
module sample_tick_gen #(
    parameter int PRESCALER = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALER - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/capture_packer.sv
// Logic-analyzer capture: synchronizes the probe bus, waits for a masked trigger,
// packs four samples per word and hands words to four read-strobed slots.
module capture_packer
    import cap_pkg::*;
#(
    parameter int SAMPLE_PRESCALER = 5,
    parameter int CAPTURE_WORDS    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [SAMPLE_W-1:0]           i_probe,
    input  logic                          i_arm,
    input  logic [SAMPLE_W-1:0]           i_trig_mask,
    input  logic [SAMPLE_W-1:0]           i_trig_value,
    input  logic [NUM_SLOTS-1:0]          i_read,
    output logic [NUM_SLOTS*WORD_W-1:0]   o_data,
    output logic [NUM_SLOTS-1:0]          o_available,
    output logic                          o_armed,
    output logic                          o_triggered,
    output logic                          o_done,
    output logic                          o_overrun
);

    localparam int PTR_W   = $clog2(NUM_SLOTS);
    localparam int IDX_W   = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = (BYTES_PER_WORD - 1) * SAMPLE_W;

    cap_state_e            state_reg, state_next;
    logic [SAMPLE_W-1:0]   probe_meta_reg, probe_sync_reg;
    logic [SHIFT_W-1:0]    shift_reg;
    logic [IDX_W-1:0]      byte_idx_reg;
    logic [PTR_W-1:0]      ptr_reg;
    logic [15:0]           wcount_reg;
    logic                  overrun_reg;
    logic [NUM_SLOTS-1:0]  avail_vec;

    logic                  tick;
    logic                  arm_accept;
    logic                  trig_match;
    logic                  store;
    logic                  complete;
    logic                  word_write;
    logic                  word_drop;
    logic                  last_word;
    logic [WORD_W-1:0]     word_full;

    sample_tick_gen #(
        .PRESCALER (SAMPLE_PRESCALER)
    ) u_tick (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (arm_accept),
        .tick  (tick)
    );

    assign arm_accept = i_arm && (state_reg == IDLE || state_reg == DONE);
    assign trig_match = ((probe_sync_reg ^ i_trig_value) & i_trig_mask) == '0;
    assign store      = tick && ((state_reg == ARMED && trig_match) || state_reg == CAPTURE);
    assign complete   = store && (byte_idx_reg == IDX_W'(BYTES_PER_WORD - 1));
    // The busy test uses the registered flag, so a same-cycle read cannot free the slot.
    assign word_write = complete && !avail_vec[ptr_reg];
    assign word_drop  = complete && avail_vec[ptr_reg];
    assign last_word  = (wcount_reg == 16'(CAPTURE_WORDS - 1));
    assign word_full  = {shift_reg, probe_sync_reg};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arm_accept) state_next = ARMED;
            ARMED:   if (store) state_next = CAPTURE;
            CAPTURE: if (word_drop || (word_write && last_word)) state_next = DONE;
            DONE:    if (arm_accept) state_next = ARMED;
        endcase
    end

    always_comb begin
        o_armed     = (state_reg == ARMED);
        o_triggered = (state_reg == CAPTURE);
        o_done      = (state_reg == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            probe_meta_reg <= '0;
            probe_sync_reg <= '0;
        end else begin
            probe_meta_reg <= i_probe;
            probe_sync_reg <= probe_meta_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            ptr_reg      <= '0;
            wcount_reg   <= '0;
            overrun_reg  <= 1'b0;
        end else if (arm_accept) begin
            byte_idx_reg <= '0;
            ptr_reg      <= '0;
            wcount_reg   <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            if (store) begin
                shift_reg    <= {shift_reg[SHIFT_W-SAMPLE_W-1:0], probe_sync_reg};
                byte_idx_reg <= complete ? '0 : byte_idx_reg + 1'b1;
            end
            if (word_write) begin
                ptr_reg    <= ptr_reg + 1'b1;
                wcount_reg <= wcount_reg + 1'b1;
            end
            if (word_drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic              avail_reg;
            logic [WORD_W-1:0] word_reg;
            logic              set_slot;

            assign set_slot = word_write && (ptr_reg == PTR_W'(gi));

            // A write and a read on the same edge leave the slot available.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    avail_reg <= 1'b0;
                    word_reg  <= '0;
                end else if (set_slot) begin
                    avail_reg <= 1'b1;
                    word_reg  <= word_full;
                end else if (i_read[gi]) begin
                    avail_reg <= 1'b0;
                end
            end

            assign avail_vec[gi]                 = avail_reg;
            assign o_data[gi*WORD_W +: WORD_W]   = word_reg;
        end
    endgenerate

    assign o_available = avail_vec;
    assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_capture_packer.sv
// Directed bench for capture_packer with a queue-based reference model checked every cycle.
module tb_capture_packer;

    localparam int P  = 5;
    localparam int CW = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   probe = 8'h00;
    logic         arm   = 1'b0;
    logic [7:0]   mask  = 8'h00;
    logic [7:0]   value = 8'h00;
    logic [3:0]   rd    = 4'h0;
    logic [127:0] data;
    logic [3:0]   avail;
    logic         armed, triggered, done, overrun;

    int total = 0;
    int bad   = 0;

    logic       auto_rd     = 1'b0;
    logic [3:0] man_rd      = 4'h0;
    int         reads_total = 0;

    always #5 clk = ~clk;

    capture_packer #(
        .SAMPLE_PRESCALER (P),
        .CAPTURE_WORDS    (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_probe      (probe),
        .i_arm        (arm),
        .i_trig_mask  (mask),
        .i_trig_value (value),
        .i_read       (rd),
        .o_data       (data),
        .o_available  (avail),
        .o_armed      (armed),
        .o_triggered  (triggered),
        .o_done       (done),
        .o_overrun    (overrun)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=IDLE 1=ARMED 2=CAPTURE 3=DONE
    int         m_state = 0;
    int         m_pcnt  = 0;
    int         m_ptr   = 0;
    int         m_wcnt  = 0;
    logic [3:0] m_avail = 4'h0;
    logic       m_ovr   = 1'b0;
    logic [31:0] m_slot [4] = '{default: 32'h0};
    logic [7:0] m_p1 = 8'h0, m_p2 = 8'h0;
    logic [7:0] m_q [$];
    logic [7:0] m_smp;
    logic [3:0] m_nav;
    logic [31:0] m_word;
    logic       m_tick, m_arm_ok, m_store;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_pcnt = 0; m_ptr = 0; m_wcnt = 0;
            m_avail = 4'h0; m_ovr = 1'b0; m_p1 = 8'h0; m_p2 = 8'h0;
            for (int k = 0; k < 4; k++) m_slot[k] = 32'h0;
            m_q.delete();
        end else begin
            m_smp    = m_p2;
            m_tick   = (m_pcnt == P - 1);
            m_arm_ok = arm && (m_state == 0 || m_state == 3);
            m_store  = m_tick && ((m_state == 1 && (m_smp & mask) == (value & mask)) || m_state == 2);
            m_nav    = m_avail & ~rd;
            if (m_arm_ok) begin
                m_state = 1; m_ovr = 1'b0; m_ptr = 0; m_wcnt = 0;
                m_q.delete();
            end else if (m_store) begin
                m_state = 2;
                m_q.push_back(m_smp);
                if (m_q.size() == 4) begin
                    m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_q.delete();
                    if (m_avail[m_ptr]) begin
                        m_ovr   = 1'b1;
                        m_state = 3;
                    end else begin
                        m_slot[m_ptr] = m_word;
                        m_nav[m_ptr]  = 1'b1;
                        m_ptr  = (m_ptr + 1) % 4;
                        m_wcnt = m_wcnt + 1;
                        if (m_wcnt == CW) m_state = 3;
                    end
                end
            end
            m_avail = m_nav;
            m_pcnt  = (m_arm_ok || m_tick) ? 0 : m_pcnt + 1;
            m_p2 = m_p1;
            m_p1 = probe;
        end
    end

    always @(negedge clk) begin
        chk("data", data, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
        chk("avail", {124'd0, avail}, {124'd0, m_avail});
        chk("status", {124'd0, armed, triggered, done, overrun},
            {124'd0, m_state == 1, m_state == 2, m_state == 3, m_ovr});
    end

    // Read strobes: either echo every available flag one cycle later, or a manual pattern.
    always @(posedge clk) begin
        #2;
        if (auto_rd) begin
            rd = avail;
            reads_total += $countones(avail);
        end else begin
            rd = man_rd;
        end
    end

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        $display("arm mask=%02h value=%02h", mask, value);
    endtask

    task automatic feed(input logic [7:0] v);
        probe = v;
        repeat (P) @(posedge clk);
        #1;
        $display("sample %02h avail=%b state=%b%b%b ovr=%b", v, avail, armed, triggered, done, overrun);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_status", {124'd0, armed, triggered, done, overrun}, 128'd0);
        chk("reset_data", data, 128'd0);
        @(posedge clk); #1;

        // Free-running trigger, two words packed MSB-first
        mask = 8'h00; value = 8'h00;
        do_arm();
        chk("arm_armed", {127'd0, armed}, 128'd1);
        for (int i = 1; i <= 8; i++) feed(8'(i * 8'h11));
        chk("w0", {96'd0, data[31:0]}, {96'd0, 32'h11223344});
        chk("w1", {96'd0, data[63:32]}, {96'd0, 32'h55667788});
        chk("avail_0011", {124'd0, avail}, {124'd0, 4'b0011});
        chk("capturing", {127'd0, triggered}, 128'd1);

        // Asynchronous reset in the middle of a capture
        @(posedge clk); #3 rst_n = 1'b0; #1;
        chk("async_rst_data", data, 128'd0);
        chk("async_rst_status", {123'd0, avail, armed, triggered, done, overrun, 1'b0}, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("reset released");

        // Masked trigger on bit 7, then eight words with prompt reads
        mask = 8'h80; value = 8'h80;
        do_arm();
        for (int i = 0; i < 10; i++) feed(8'h00);
        chk("still_armed", {127'd0, armed}, 128'd1);
        feed(8'h9A);
        chk("trig_fired", {127'd0, triggered}, 128'd1);
        for (int i = 1; i <= 3; i++) feed(8'(i));
        chk("trig_word", {96'd0, data[31:0]}, {96'd0, 32'h9A010203});
        chk("trig_avail", {124'd0, avail}, {124'd0, 4'b0001});
        auto_rd = 1'b1;
        for (int i = 4; i <= 8'h1F; i++) feed(8'(i));
        repeat (3) @(posedge clk); #1;
        chk("all_done", {126'd0, done, overrun}, {126'd0, 2'b10});
        chk("slot0_w5", {96'd0, data[31:0]}, {96'd0, 32'h10111213});
        chk("slot3_w8", {96'd0, data[127:96]}, {96'd0, 32'h1C1D1E1F});
        chk("reads", 128'(reads_total), 128'd8);
        chk("drained", {124'd0, avail}, 128'd0);
        auto_rd = 1'b0;
        repeat (2) @(posedge clk); #1;

        // No reads: fifth completion overruns
        mask = 8'h00; value = 8'h00;
        do_arm();
        for (int i = 8'h20; i <= 8'h33; i++) feed(8'(i));
        chk("ovr_flags", {126'd0, done, overrun}, {126'd0, 2'b11});
        chk("ovr_avail", {124'd0, avail}, {124'd0, 4'b1111});
        chk("ovr_slot0", {96'd0, data[31:0]}, {96'd0, 32'h20212223});
        chk("ovr_slot3", {96'd0, data[127:96]}, {96'd0, 32'h2C2D2E2F});
        do_arm();
        chk("rearm_ovr", {126'd0, armed, overrun}, {126'd0, 2'b10});
        chk("rearm_avail", {124'd0, avail}, {124'd0, 4'b1111});

        // Read of slot 0 on the very edge its next word completes
        for (int i = 8'h40; i <= 8'h42; i++) feed(8'(i));
        probe = 8'h43;
        repeat (P - 1) @(posedge clk);
        #1 man_rd = 4'b0001;
        @(posedge clk);
        #1 man_rd = 4'b0000;
        $display("sample 43 with same-edge read of slot 0");
        @(posedge clk); #1;
        chk("same_ovr", {126'd0, done, overrun}, {126'd0, 2'b11});
        chk("same_avail", {124'd0, avail}, {124'd0, 4'b1110});
        chk("same_slot0", {96'd0, data[31:0]}, {96'd0, 32'h20212223});

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_packer.md
Name: capture_packer

Overview:
- Front end of the logic analyzer. Samples an 8-bit probe bus at a prescaled rate and waits for a masked trigger.
- After the trigger, packs four consecutive samples into each 32-bit word.
- Completed words go into four word slots, presented as a 128-bit bus with per-slot available flags.
- Sits directly upstream of the serial transfer stage, which consumes slots via per-slot read strobes.

Parameters:
- SAMPLE_PRESCALER, 5: clocks per sample tick (≥1).
- CAPTURE_WORDS, 8: number of 32-bit words captured per trigger (≥1, ≤65535).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_probe  in  8  asynchronous probe inputs.
- i_arm  in  1  single-cycle pulse; arms the trigger.
- i_trig_mask  in  8  1 = bit participates in the trigger compare.
- i_trig_value  in  8  required value of the masked bits.
- i_read  in  4  per-slot pulse from the transfer stage; clears the matching available bit.
- o_data  out  128  slot k occupies bits [32k+31:32k].
- o_available  out  4  slot k holds an unread word.
- o_armed  out  1  high in ARMED.
- o_triggered  out  1  high in CAPTURE.
- o_done  out  1  high in DONE.
- o_overrun  out  1  sticky; a slot was still unread when needed.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE.
  - o_data=0, o_available=0, all status outputs=0.
  - Slot pointer=0, byte index=0, word count=0, prescaler=0.
  - Synchronizer flops=0.
- Probe path: 2-FF synchronizer per bit; samples use the synchronized value, giving 2 cycles latency from pin.
- Sample tick:
  - Prescaler counts 0..SAMPLE_PRESCALER-1; tick is asserted on the cycle the count equals SAMPLE_PRESCALER-1, then the count wraps to 0.
  - The prescaler is reset to 0 on an accepted i_arm.
  - SAMPLE_PRESCALER=1 gives a tick every cycle.
- States:
  - IDLE: i_arm → ARMED.
  - ARMED: on a tick, if (sample & mask) == (value & mask), go to CAPTURE. That same sample is stored as byte 0 of the first word. Mask=0 triggers on the first tick.
  - CAPTURE: each tick stores one sample.
  - DONE: i_arm → ARMED.
- Accepting i_arm (IDLE or DONE): clears o_overrun, slot pointer, byte index and word count. It does not clear o_available or o_data. i_arm is ignored in ARMED and CAPTURE.
- Packing order: first sample of a word goes to bits [31:24], then [23:16], [15:8], [7:0].
- Word build: the word is built in an internal shift register. The slot register is written only on word completion.
- Word completion (4th byte), on that clock edge:
  - If o_available[ptr]==0: write the word to slot ptr, set o_available[ptr], ptr = (ptr+1) mod 4, word count+1.
  - If word count reaches CAPTURE_WORDS: go to DONE.
  - If o_available[ptr]==1 (including when i_read[ptr] is high on this same cycle): the word is dropped, o_overrun=1, go to DONE. The slot is left untouched.
- Read handling:
  - i_read[k] high on a clock clears o_available[k].
  - If a set and a clear hit the same slot in the same cycle, set wins.
  - i_read on an already-clear slot has no effect.
  - o_data of a slot is stable while its available bit is 1.
- Multiple i_read bits may be high in the same cycle; each clears its own slot.
- Reset mid-capture aborts immediately. No partial word is ever presented.

Decomposition:
- Package cap_pkg:
  - State enum {IDLE, ARMED, CAPTURE, DONE}.
  - Constants NUM_SLOTS=4, WORD_W=32, SAMPLE_W=8, BYTES_PER_WORD=4.
- Sub-module sample_tick_gen: prescaler counter with a sync clear input; outputs the one-cycle tick.

Test Plan:
- Reset with i_rst_n=0 mid-run → all outputs 0 asynchronously; state IDLE after release.
- Prescaler=5, mask=0, i_arm, probe sequence 0x11,0x22,…,0x88 one per tick:
  - o_data[31:0]=0x11223344, o_available=0001.
  - Then o_data[63:32]=0x55667788, o_available=0011.
  - Words complete on ticks 4 and 8.
- mask=0x80, value=0x80, probe=0x00 for 10 ticks then 0x9A → ARMED throughout the zeros; the first word starts with byte 0x9A.
- CAPTURE_WORDS=8, bench pulses i_read[k] within 1 tick of each set → 8 words delivered; slots wrap 0,1,2,3,0,…; o_done=1; o_overrun=0.
- No reads issued → 4 words fill slots 0–3; the 5th completion sets o_overrun=1 and o_done=1 with slot 0 data unchanged. Re-arm clears o_overrun only; o_available stays 1111.
- Same-cycle case: i_read[0] coincides with the completion targeting slot 0 → overrun (the check uses the pre-clear flag); o_available[0] ends at 0.
